bcd_digit_counter: RTL and testbench

Multi-digit decimal up/down counter with a built-in clock-enable prescaler, synchronous clear and parallel load. It produces one 4-bit BCD nibble per display digit, and each nibble drives one BCD-to-seven-segment decoder directly. It sits immediately upstream of the hex display decoders in the counters lab top level, between the board clock and the HEX outputs.

---
 rtl/bcd_digit_counter_pkg.sv | 24 ++
 rtl/bcd_digit_counter_cell.sv | 43 ++++
 rtl/bcd_digit_counter.sv | 87 ++++++++
 tb/tb_bcd_digit_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_digit_counter_pkg.sv
// bcd_digit_counter_pkg
// Shared constants and helpers for the BCD counter and the display
// decoders downstream of it.
//   DIGIT_W        : nibble width of one BCD digit
//   BCD_MAX/BCD_MIN: legal digit range
//   bcd_sanitize() : maps an out-of-range nibble to BCD_MIN
//   presc_width()  : prescaler register width for a given divide ratio
package bcd_digit_counter_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
    localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MIN : nibble;
    endfunction

    // A divide-by-1 prescaler still needs a 1-bit register to stay legal.
    function automatic int presc_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/bcd_digit_counter_cell.sv
// bcd_digit_cell
// One decimal digit register of the cascaded counter.
//   clk, reset     : clock, synchronous active-high reset
//   clear          : synchronous clear to 0 (same effect as reset)
//   load           : load load_nibble (values >9 load as 0)
//   load_nibble    : parallel load value for this digit
//   step           : advance this digit by one in direction up
//   up             : 1 = increment, 0 = decrement
//   q              : current digit value, always 0..9
//   carry          : step is active and this digit rolls over (9 up / 0 down)
module bcd_digit_cell
    import bcd_digit_counter_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_nibble,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    always_comb begin
        carry = step & (up ? (q == BCD_MAX) : (q == BCD_MIN));
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= bcd_sanitize(load_nibble);
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + DIGIT_W'(1);
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter
// Multi-digit decimal up/down counter with a clock-enable prescaler,
// synchronous clear and parallel load. Feeds the seven-segment decoders.
//   NUM_DIGITS : cascaded digits (1..8)
//   TICK_DIV   : enabled clock cycles per count step (>= 1)
//   clk, reset : clock, synchronous active-high reset
//   en         : count enable; low freezes prescaler and digits
//   up         : direction sampled at each tick (1 = up)
//   clear      : synchronous clear of digits and prescaler
//   load       : synchronous parallel load from load_val
//   load_val   : nibble k -> digit k, digit 0 least significant
//   digits     : registered BCD count, same ordering as load_val
//   wrap       : one-cycle pulse when the whole count rolls over
module bcd_digit_counter
    import bcd_digit_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          up,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          wrap
);

    localparam int            PW         = presc_width(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]         presc;
    logic                  tick;
    logic [NUM_DIGITS-1:0] step;
    logic [NUM_DIGITS-1:0] carry;

    // With TICK_DIV = 1 the prescaler is pinned at 0 and tick follows en.
    assign tick = en && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || load) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else if (en) begin
            presc <= presc + PW'(1);
        end
    end

    // Ripple enable: digit k steps only when every lower digit rolls over.
    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            if (k == 0) begin : g_lsd
                assign step[k] = tick;
            end else begin : g_upper
                assign step[k] = step[k-1] & carry[k-1];
            end

            bcd_digit_cell u_cell (
                .clk         (clk),
                .reset       (reset),
                .clear       (clear),
                .load        (load),
                .load_nibble (load_val[DIGIT_W*k +: DIGIT_W]),
                .step        (step[k]),
                .up          (up),
                .q           (digits[DIGIT_W*k +: DIGIT_W]),
                .carry       (carry[k])
            );
        end
    endgenerate

    // Cells already give clear/load priority over step, but the top carry
    // is still combinationally live in those cycles, so mask it here.
    always_ff @(posedge clk) begin
        if (reset || clear || load) begin
            wrap <= 1'b0;
        end else begin
            wrap <= carry[NUM_DIGITS-1];
        end
    end

endmodule

// File: tb/tb_bcd_digit_counter.sv
module tb_bcd_digit_counter;

    localparam int ND  = 4;
    localparam int MOD = 10000;

    typedef struct {
        int val;
        int p;
        bit wrap;
    } mstate_t;

    logic        clk = 1'b0;
    logic        reset, en, up, clear, load;
    logic [15:0] load_val;
    logic [15:0] dig4, dig1;
    logic        wrap4, wrap1;

    int tests = 0;
    int fails = 0;

    mstate_t m4, m1;

    always #5 clk = ~clk;

    bcd_digit_counter #(.NUM_DIGITS(ND), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .digits(dig4), .wrap(wrap4)
    );

    bcd_digit_counter #(.NUM_DIGITS(ND), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear),
        .load(load), .load_val(load_val), .digits(dig1), .wrap(wrap1)
    );

    // Reference model: the count is a plain integer modulo 10^ND.
    function automatic int from_bcd(input logic [15:0] lv);
        int v = 0;
        int w = 1;
        logic [3:0] nib;
        for (int k = 0; k < ND; k++) begin
            nib = lv[4*k +: 4];
            v += ((nib > 4'd9) ? 0 : int'(nib)) * w;
            w *= 10;
        end
        return v;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int k = 0; k < ND; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic mstate_t mstep(input mstate_t s, input int td,
                                      input bit r, input bit c, input bit l,
                                      input bit e, input bit u,
                                      input logic [15:0] lv);
        mstate_t n = s;
        n.wrap = 1'b0;
        if (r || c) begin
            n.val = 0;
            n.p   = 0;
        end else if (l) begin
            n.val = from_bcd(lv);
            n.p   = 0;
        end else if (e) begin
            if (s.p == td - 1) begin
                n.p = 0;
                if (u) begin
                    n.wrap = (s.val == MOD - 1);
                    n.val  = (s.val + 1) % MOD;
                end else begin
                    n.wrap = (s.val == 0);
                    n.val  = (s.val + MOD - 1) % MOD;
                end
            end else begin
                n.p = s.p + 1;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: advance both models with the inputs the DUTs see, then
    // compare every output #1 after the edge.
    task automatic cycle();
        @(posedge clk);
        m4 = mstep(m4, 4, reset, clear, load, en, up, load_val);
        m1 = mstep(m1, 1, reset, clear, load, en, up, load_val);
        #1;
        chk("dig4_model",  32'(dig4),  32'(to_bcd(m4.val)));
        chk("wrap4_model", 32'(wrap4), 32'(m4.wrap));
        chk("dig1_model",  32'(dig1),  32'(to_bcd(m1.val)));
        chk("wrap1_model", 32'(wrap1), 32'(m1.wrap));
    endtask

    initial begin
        m4 = '{val: 0, p: 0, wrap: 1'b0};
        m1 = '{val: 0, p: 0, wrap: 1'b0};
        reset = 1'b1; en = 1'b1; up = 1'b1; clear = 1'b0; load = 1'b0;
        load_val = 16'h0000;

        cycle();
        cycle();
        chk("reset_digits", 32'(dig4), 32'h0000);
        chk("reset_wrap",   32'(wrap4), 32'h0);

        // First step TICK_DIV edges after reset; 0x0010 after 40 edges.
        reset = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (i == 3) chk("first_step_pre", 32'(dig4), 32'h0000);
            if (i == 4) chk("first_step",     32'(dig4), 32'h0001);
        end
        chk("after40_div4", 32'(dig4), 32'h0010);
        chk("after40_div1", 32'(dig1), 32'h0040);

        // Up wrap.
        load = 1'b1; load_val = 16'h9998;
        cycle();
        load = 1'b0;
        cycle();
        chk("upwrap_9999", 32'(dig1), 32'h9999);
        chk("upwrap_w0",   32'(wrap1), 32'h0);
        cycle();
        chk("upwrap_0000", 32'(dig1), 32'h0000);
        chk("upwrap_w1",   32'(wrap1), 32'h1);
        cycle();
        chk("upwrap_0001", 32'(dig1), 32'h0001);
        chk("upwrap_w2",   32'(wrap1), 32'h0);

        // Down wrap.
        load = 1'b1; load_val = 16'h0001; up = 1'b0;
        cycle();
        load = 1'b0;
        cycle();
        chk("dnwrap_0000", 32'(dig1), 32'h0000);
        cycle();
        chk("dnwrap_9999", 32'(dig1), 32'h9999);
        chk("dnwrap_w1",   32'(wrap1), 32'h1);
        cycle();
        chk("dnwrap_9998", 32'(dig1), 32'h9998);
        chk("dnwrap_w0",   32'(wrap1), 32'h0);

        // Illegal nibbles load as 0; clear on a tick cycle wins.
        load = 1'b1; load_val = 16'hA3F7; up = 1'b1;
        cycle();
        chk("load_sanitize", 32'(dig4), 32'h0307);
        load = 1'b0;
        cycle(); cycle(); cycle();
        chk("pre_clear_hold", 32'(dig4), 32'h0307);
        clear = 1'b1;
        cycle();
        chk("clear_on_tick",   32'(dig4), 32'h0000);
        chk("clear_on_tick_w", 32'(wrap4), 32'h0);
        clear = 1'b0;

        // en low for 3 cycles stretches the interval to 7 edges.
        cycle(); cycle();
        en = 1'b0;
        cycle(); cycle(); cycle();
        en = 1'b1;
        cycle();
        chk("stretch_pre", 32'(dig4), 32'h0000);
        cycle();
        chk("stretch_step", 32'(dig4), 32'h0001);

        // Only the direction present at the tick applies.
        up = 1'b1; cycle();
        up = 1'b0; cycle();
        up = 1'b1; cycle();
        chk("dir_hold", 32'(dig4), 32'h0001);
        up = 1'b0; cycle();
        chk("dir_at_tick", 32'(dig4), 32'h0000);

        // Reset beats load and clear; prescaler restarts.
        load = 1'b1; load_val = 16'h0456; up = 1'b1;
        cycle();
        chk("load_0456", 32'(dig4), 32'h0456);
        reset = 1'b1; clear = 1'b1; load_val = 16'h9999;
        cycle();
        chk("reset_priority", 32'(dig4), 32'h0000);
        reset = 1'b0; clear = 1'b0; load = 1'b0;
        cycle(); cycle(); cycle();
        chk("restart_pre", 32'(dig4), 32'h0000);
        cycle();
        chk("restart_step", 32'(dig4), 32'h0001);

        // Randomized phase against the model.
        for (int i = 0; i < 1500; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 79) == 0);
            load  = ($urandom_range(0, 29) == 0);
            en    = ($urandom_range(0, 9) < 8);
            up    = ($urandom_range(0, 9) < 5) ? up : ~up;
            case ($urandom_range(0, 3))
                0:       load_val = 16'h9997;
                1:       load_val = 16'h0002;
                default: load_val = 16'($urandom);
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
